// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch-side skid buffer: state encoding and bubble word.
package pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // All-zero word doubles as the NOP/bubble seen by decode after reset or flush.
  localparam logic [31:0] SKID_BUBBLE = 32'h0000_0000;

  function automatic logic [1:0] skid_count(input skid_state_t st);
    case (st)
      SKID_ONE:  skid_count = 2'd1;
      SKID_FULL: skid_count = 2'd2;
      default:   skid_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/reg_sync_rst_en.sv
// Data register with synchronous active-low clear and load enable.
module reg_sync_rst_en #(
  parameter int                WID_DATA  = 32,
  parameter logic [WID_DATA-1:0] RST_VALUE = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [WID_DATA-1:0] D,
  output logic [WID_DATA-1:0] Q
);

  always_ff @(posedge Clock) begin
    if (!Reset)      Q <= RST_VALUE;
    else if (Enable) Q <= D;
  end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer between fetch and the IF/ID register.
//   state      | meaning
//   SKID_EMPTY | no word held; InReady=1, OutValid=0
//   SKID_ONE   | head word in main; InReady=1, OutValid=1
//   SKID_FULL  | main and skid both hold words; InReady=0
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int                  WID_DATA  = 32,
  parameter logic [WID_DATA-1:0] RST_VALUE = WID_DATA'(SKID_BUBBLE)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Flush,
  input  logic                InValid,
  output logic                InReady,
  input  logic [WID_DATA-1:0] InData,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [WID_DATA-1:0] OutData,
  output logic [1:0]          Count
);

  skid_state_t         state;
  skid_state_t         state_nxt;
  logic                accept;
  logic                consume;
  logic                main_en;
  logic                skid_en;
  logic                data_rst_n;
  logic                main_vld;
  logic                skid_vld;
  logic [WID_DATA-1:0] main_d;
  logic [WID_DATA-1:0] skid_q;

  assign accept     = InValid & InReady;
  assign consume    = OutValid & OutReady;
  assign data_rst_n = Reset & ~Flush;

  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    main_d    = InData;
    case (state)
      SKID_EMPTY: begin
        if (accept) begin
          state_nxt = SKID_ONE;
          main_en   = 1'b1;
        end
      end
      SKID_ONE: begin
        if (accept && consume) begin
          main_en = 1'b1;
        end else if (accept) begin
          state_nxt = SKID_FULL;
          skid_en   = 1'b1;
        end else if (consume) begin
          state_nxt = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // InReady is low here, so the only move is popping skid into main.
        main_d = skid_q;
        if (consume) begin
          state_nxt = SKID_ONE;
          main_en   = 1'b1;
        end
      end
      default: state_nxt = SKID_EMPTY;
    endcase
  end

  // Outputs are decoded from the next state so InReady never depends on OutReady combinationally.
  always_ff @(posedge Clock) begin
    if (!Reset || Flush) begin
      state    <= SKID_EMPTY;
      InReady  <= 1'b1;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      Count    <= 2'd0;
    end else begin
      state    <= state_nxt;
      InReady  <= (state_nxt != SKID_FULL);
      main_vld <= (state_nxt != SKID_EMPTY);
      skid_vld <= (state_nxt == SKID_FULL);
      Count    <= skid_count(state_nxt);
    end
  end

  assign OutValid = main_vld;

  reg_sync_rst_en #(
    .WID_DATA  (WID_DATA),
    .RST_VALUE (RST_VALUE)
  ) u_main (
    .Clock  (Clock),
    .Reset  (data_rst_n),
    .Enable (main_en),
    .D      (main_d),
    .Q      (OutData)
  );

  reg_sync_rst_en #(
    .WID_DATA  (WID_DATA),
    .RST_VALUE (RST_VALUE)
  ) u_skid (
    .Clock  (Clock),
    .Reset  (data_rst_n),
    .Enable (skid_en),
    .D      (InData),
    .Q      (skid_q)
  );

  logic unused_skid_vld;
  assign unused_skid_vld = skid_vld;

endmodule
